// File: rtl/sw_led_ctrl_if.sv
// Bundle between the board switches and LED pins and the switch-to-LED controller.
// The master side drives raw switches and mode; the controller drives debounced state and LEDs.
`timescale 1ns/1ps
interface sw_led_ctrl_if #(
    parameter int N_SW  = 2,
    parameter int N_LED = 8
);
    logic [N_SW-1:0]  sw;
    logic [1:0]       mode;
    logic [N_SW-1:0]  sw_db;
    logic [N_LED-1:0] ledr;

    modport master (
        output sw,
        output mode,
        input  sw_db,
        input  ledr
    );

    modport slave (
        input  sw,
        input  mode,
        output sw_db,
        output ledr
    );
endinterface

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: per-switch 2-flop sync and debounce, tick prescaler,
// and a registered LED driver with direct, parity, blink and marquee display modes.
`timescale 1ns/1ps
module sw_led_ctrl #(
    parameter int N_SW      = 2,
    parameter int N_LED     = 8,
    parameter int DB_CYCLES = 4,
    parameter int DIV       = 8
) (
    input  logic          clk,
    input  logic          rst,
    sw_led_ctrl_if.slave  bus
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int DIV_W = $clog2(DIV);

    localparam logic [1:0] MODE_DIRECT  = 2'd0;
    localparam logic [1:0] MODE_PARITY  = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_MARQUEE = 2'd3;

    logic [N_SW-1:0]  s1_reg;
    logic [N_SW-1:0]  s2_reg;
    logic [N_SW-1:0]  sw_db_reg;
    logic [N_SW-1:0]  sw_db_next;

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             tick;

    logic             phase_reg;
    logic             phase_next;
    logic [N_LED-1:0] pos_reg;
    logic [N_LED-1:0] pos_next;

    logic [N_LED-1:0] direct_map;
    logic [N_LED-1:0] ledr_reg;
    logic [N_LED-1:0] ledr_next;

    // Raw switches are asynchronous to clk; two flops before anything looks at them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= bus.sw;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             db_bit_next;

            // A change is accepted only after DB_CYCLES consecutive mismatching samples.
            always_comb begin
                cnt_next    = '0;
                db_bit_next = sw_db_reg[gi];
                if (s2_reg[gi] != sw_db_reg[gi]) begin
                    if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                        db_bit_next = s2_reg[gi];
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign sw_db_next[gi] = db_bit_next;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_db_reg <= '0;
        end else begin
            sw_db_reg <= sw_db_next;
        end
    end

    // Free-running prescaler; deliberately independent of mode so timing never restarts.
    assign tick = (div_reg == DIV_W'(DIV - 1));

    always_comb begin
        div_next = div_reg + DIV_W'(1);
        if (tick) begin
            div_next = '0;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        pos_next   = pos_reg;
        if (tick) begin
            phase_next = ~phase_reg;
            // Direction comes from the pre-edge debounced state.
            if (sw_db_reg[0]) begin
                pos_next = {pos_reg[N_LED-2:0], pos_reg[N_LED-1]};
            end else begin
                pos_next = {pos_reg[0], pos_reg[N_LED-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg   <= '0;
            phase_reg <= 1'b0;
            pos_reg   <= N_LED'(1);
        end else begin
            div_reg   <= div_next;
            phase_reg <= phase_next;
            pos_reg   <= pos_next;
        end
    end

    // Zero-extend or truncate the debounced switches onto the LED width.
    generate
        for (gi = 0; gi < N_LED; gi++) begin : g_direct
            if (gi < N_SW) begin : g_sw
                assign direct_map[gi] = sw_db_reg[gi];
            end else begin : g_zero
                assign direct_map[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        ledr_next = '0;
        case (bus.mode)
            MODE_DIRECT:  ledr_next = direct_map;
            MODE_PARITY:  ledr_next = {{(N_LED-1){1'b0}}, ^sw_db_reg};
            MODE_BLINK:   ledr_next = {N_LED{phase_reg}};
            MODE_MARQUEE: ledr_next = pos_reg;
            default:      ledr_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ledr_reg <= '0;
        end else begin
            ledr_reg <= ledr_next;
        end
    end

    assign bus.sw_db = sw_db_reg;
    assign bus.ledr  = ledr_reg;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Scoreboard bench for sw_led_ctrl: timed expectations are queued as stimulus is applied
// and compared on the falling edge of the cycle they fall due.
`timescale 1ns/1ps
module tb_sw_led_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    sw_led_ctrl_if #(.N_SW(2), .N_LED(8)) bus ();

    sw_led_ctrl #(
        .N_SW(2), .N_LED(8), .DB_CYCLES(4), .DIV(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sig;   // 0 = ledr, 1 = sw_db
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int due, input int sig, input logic [31:0] exp, input string tag);
        exp_t e;
        e.due = due;
        e.sig = sig;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t keep[$];
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                if (sb[i].sig == 0) check(sb[i].tag, 32'(bus.ledr), sb[i].exp);
                else                check(sb[i].tag, 32'(bus.sw_db), sb[i].exp);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic drive(input logic [1:0] s, input logic [1:0] m);
        bus.sw   = s;
        bus.mode = m;
        $display("cycle %0d: drive sw=%b mode=%0d", cyc, s, m);
    endtask

    // Asserts reset away from any edge, checks it took effect at once, holds it
    // for two edges and releases on a falling edge with new inputs applied.
    task automatic do_reset(input logic [1:0] s, input logic [1:0] m);
        rst = 1'b0;
        #1;
        check("async_rst_led", 32'(bus.ledr), 32'h00);
        check("async_rst_db", 32'(bus.sw_db), 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_led", 32'(bus.ledr), 32'h00);
            check("rst_hold_db", 32'(bus.sw_db), 32'h0);
        end
        drive(s, m);
        rst = 1'b1;
    endtask

    initial begin
        int c;
        rst      = 1'b0;
        bus.sw   = 2'b00;
        bus.mode = 2'd0;
        repeat (3) @(negedge clk);
        check("init_led", 32'(bus.ledr), 32'h00);
        check("init_db", 32'(bus.sw_db), 32'h0);

        // Blink from reset, with both switches on so the later reset has state to clear.
        drive(2'b11, 2'd2);
        rst = 1'b1;
        c = cyc;
        for (int k = 1; k <= 28; k++)
            push(c + k, 0, (((k - 1) / 8) % 2 == 1) ? 32'hFF : 32'h00, "blink");
        push(c + 5, 1, 32'h0, "db11_pre");
        push(c + 6, 1, 32'h3, "db11");
        repeat (28) @(negedge clk);
        #2;
        do_reset(2'b00, 2'd0);

        // Three-cycle glitch must be filtered out.
        repeat (2) @(negedge clk);
        c = cyc;
        drive(2'b01, 2'd0);
        for (int k = 1; k <= 10; k++) push(c + k, 1, 32'h0, "glitch_db");
        push(c + 10, 0, 32'h00, "glitch_led");
        repeat (3) @(negedge clk);
        drive(2'b00, 2'd0);
        repeat (7) @(negedge clk);

        // Held change: sw_db at edge 6, LED one edge later.
        c = cyc;
        drive(2'b01, 2'd0);
        push(c + 5, 1, 32'h0, "db_lat_pre");
        push(c + 6, 1, 32'h1, "db_lat");
        push(c + 6, 0, 32'h00, "direct_pre");
        push(c + 7, 0, 32'h01, "direct_01");
        repeat (8) @(negedge clk);

        // Parity mode.
        c = cyc;
        drive(2'b01, 2'd1);
        push(c + 1, 0, 32'h01, "par_01");
        repeat (2) @(negedge clk);
        c = cyc;
        drive(2'b11, 2'd1);
        push(c + 6, 1, 32'h3, "db_11b");
        push(c + 7, 0, 32'h00, "par_11");
        repeat (8) @(negedge clk);
        c = cyc;
        drive(2'b10, 2'd1);
        push(c + 6, 1, 32'h2, "db_10");
        push(c + 7, 0, 32'h01, "par_10");
        repeat (8) @(negedge clk);
        c = cyc;
        drive(2'b10, 2'd0);
        push(c + 1, 0, 32'h02, "direct_10");
        repeat (2) @(negedge clk);

        // Marquee rotating left through a full wrap, then a mode change on a tick edge.
        @(negedge clk);
        #2;
        do_reset(2'b01, 2'd3);
        c = cyc;
        for (int k = 1; k <= 79; k++)
            push(c + k, 0, 32'h1 << (((k - 1) / 8) % 8), "marq_left");
        repeat (79) @(negedge clk);
        drive(2'b01, 2'd2);
        push(c + 80, 0, 32'hFF, "tick_mode_chg");
        push(c + 81, 0, 32'h00, "post_tick");
        repeat (3) @(negedge clk);

        // Marquee rotating right from 0x01, reset at 0x10, restart rotating left.
        #2;
        do_reset(2'b00, 2'd3);
        c = cyc;
        for (int k = 1; k <= 36; k++)
            push(c + k, 0, 32'h1 << ((8 - ((k - 1) / 8) % 8) % 8), "marq_right");
        repeat (36) @(negedge clk);
        check("pre_rst_pos", 32'(bus.ledr), 32'h10);
        #2;
        do_reset(2'b01, 2'd3);
        c = cyc;
        for (int k = 1; k <= 16; k++)
            push(c + k, 0, (k <= 8) ? 32'h01 : 32'h02, "marq_restart");
        repeat (17) @(negedge clk);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

endmodule
